// File: rtl/mem_sequencer_if.sv
// Request/SRAM bundle between the two requesters, the sequencer and the SRAM pads.
// reqN is a level held by the requester until it samples doneN=1; doneN is a one-cycle pulse.
interface mem_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] Mem_ADDR;
    logic [DATA_W-1:0] Mem_DOUT;
    logic [DATA_W-1:0] Mem_DIN;
    logic              Mem_DOE;
    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Mem_DIN,
        output done0, done1, rdata, Mem_ADDR, Mem_DOUT, Mem_DOE,
               Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, Mem_DIN,
        input  done0, done1, rdata, Mem_ADDR, Mem_DOUT, Mem_DOE,
               Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/mem_sequencer.sv
// Two-port round-robin SRAM sequencer: arbitrate in IDLE, then run a fixed
// setup / strobe (WAIT_CYCLES wide) / recover sequence on the active-low strobes.
module mem_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_sequencer_if.slave bus,
    output logic [1:0]     o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_any_req;
    logic              w_grant1;

    // On a tie the port that did not own the previous transaction wins.
    assign w_any_req = bus.req0 | bus.req1;
    assign w_grant1  = bus.req1 & (~bus.req0 | ~r_last);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next_state = S_SETUP;
            S_SETUP:   w_next_state = S_STROBE;
            S_STROBE:  if (r_cnt == 4'd0) w_next_state = S_RECOVER;
            S_RECOVER: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= 4'd0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant1;
                        r_last  <= w_grant1;
                        r_we    <= w_grant1 ? bus.we1    : bus.we0;
                        r_addr  <= w_grant1 ? bus.addr1  : bus.addr0;
                        r_wdata <= w_grant1 ? bus.wdata1 : bus.wdata0;
                    end
                end
                S_SETUP: r_cnt <= CNT_LOAD;
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) r_rdata <= bus.Mem_DIN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so reset forces the strobes high at once.
    always_comb begin
        bus.Mem_CE   = (r_state == S_IDLE);
        bus.Mem_UB   = (r_state == S_IDLE);
        bus.Mem_LB   = (r_state == S_IDLE);
        bus.Mem_OE   = !((r_state == S_STROBE) && !r_we);
        bus.Mem_WE   = !((r_state == S_STROBE) && r_we);
        bus.Mem_DOE  = (r_state != S_IDLE) && r_we;
        bus.done0    = (r_state == S_RECOVER) && !r_owner;
        bus.done1    = (r_state == S_RECOVER) && r_owner;
        bus.Mem_ADDR = r_addr;
        bus.Mem_DOUT = r_wdata;
        bus.rdata    = r_rdata;
        o_dbg_state  = r_state;
    end
endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed test-plan steps plus random two-port traffic,
// checked cycle by cycle against a transaction-level model and an SRAM model.
module tb_mem_sequencer;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    mem_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus15 ();
    logic [1:0] dbg0, dbg1, dbg15;

    mem_sequencer #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W))
        dut (.Clk(clk), .Reset(reset_n), .bus(bus), .o_dbg_state(dbg0));
    mem_sequencer #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1))
        dut_w1 (.Clk(clk), .Reset(reset_n), .bus(bus1), .o_dbg_state(dbg1));
    mem_sequencer #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(15))
        dut_w15 (.Clk(clk), .Reset(reset_n), .bus(bus15), .o_dbg_state(dbg15));

    // SRAM pad model for the main instance; fixed read data for the width-test instances.
    logic [15:0] sram    [0:65535];
    logic [15:0] exp_mem [0:65535];
    assign bus.Mem_DIN   = sram[bus.Mem_ADDR];
    assign bus1.Mem_DIN  = 16'hA5A5;
    assign bus15.Mem_DIN = 16'h5A5A;
    always @(posedge clk)
        if (reset_n && !bus.Mem_CE && !bus.Mem_WE) sram[bus.Mem_ADDR] = bus.Mem_DOUT;

    // Reference model: k = cycle number within the current transaction, 0 = idle.
    int          k;
    logic        m_owner, m_last, m_we;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [15:0] exp_q[$];
    int          n_tests, n_fail, cyc;
    bit          hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_last = 1'b1;
        m_rdata = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic p1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (k == 0) begin
            if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) p1 = ~m_last;
                else                      p1 = bus.req1;
                m_owner = p1;
                m_last  = p1;
                m_we    = p1 ? bus.we1    : bus.we0;
                m_addr  = p1 ? bus.addr1  : bus.addr0;
                m_wdata = p1 ? bus.wdata1 : bus.wdata0;
                if (!m_we) exp_q.push_back(exp_mem[m_addr]);
                k = 1;
            end
        end else if (k == W + 2) begin
            if (m_we) exp_mem[m_addr] = m_wdata;
            k = 0;
        end else begin
            if (k == W + 1 && !m_we) m_rdata = exp_mem[m_addr];
            k++;
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE,
                bus.Mem_DOE, bus.done0, bus.done1};
    endfunction

    task automatic check_outputs();
        logic act, str, rec;
        logic [7:0] ev;
        act = (k != 0);
        str = (k >= 2) && (k <= W + 1);
        rec = (k == W + 2);
        ev = {!act, !act, !act, !(str && !m_we), !(str && m_we), act && m_we,
              rec && !m_owner, rec && m_owner};
        chk("strobes", 32'(obs_vec()), 32'(ev));
        chk("bus_safety", 32'(bus.Mem_DOE & ~bus.Mem_OE), 32'd0);
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        if (act) chk("addr", 32'(bus.Mem_ADDR), 32'(m_addr));
        if (act && m_we) chk("dout", 32'(bus.Mem_DOUT), 32'(m_wdata));
        if (rec && !m_we) begin
            chk("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk("sb_rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
        if (!hold) begin
            if (bus.done0) bus.req0 = 1'b0;
            if (bus.done1) bus.req1 = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end else begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int stamp[$];
        int d1c, d15c, oe1, oe15, guard;
        n_tests = 0; n_fail = 0; cyc = 0; hold = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.we0 = 0; bus1.we1 = 0;
        bus1.addr0 = 0; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;
        bus15.req0 = 0; bus15.req1 = 0; bus15.we0 = 0; bus15.we1 = 0;
        bus15.addr0 = 0; bus15.addr1 = 0; bus15.wdata0 = 0; bus15.wdata1 = 0;
        for (int i = 0; i < 65536; i++) begin
            sram[i] = 16'($urandom);
            exp_mem[i] = sram[i];
        end
        sram[16'h0010] = 16'hBEEF;
        exp_mem[16'h0010] = 16'hBEEF;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'(obs_vec()), 32'h0000_00F8);
        chk("rst_addr", 32'(bus.Mem_ADDR), 32'd0);
        chk("rst_dout", 32'(bus.Mem_DOUT), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Read on port 0
        issue(0, 1'b0, 16'h0010, 16'h0000);
        run(6);
        chk("read_p0_rdata", 32'(bus.rdata), 32'h0000_BEEF);

        // Write on port 1
        issue(1, 1'b1, 16'h0200, 16'h1234);
        run(6);
        chk("write_p1_mem", 32'(sram[16'h0200]), 32'h0000_1234);

        // Both ports held high from reset
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        hold = 1'b1;
        issue(0, 1'b0, 16'h0010, 16'h0000);
        issue(1, 1'b0, 16'h0200, 16'h0000);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done0) begin order.push_back(0); stamp.push_back(cyc); end
            if (bus.done1) begin order.push_back(1); stamp.push_back(cyc); end
            if (bus.done0 || bus.done1)
                chk("tie_rdata", 32'(bus.rdata), bus.done0 ? 32'h0000_BEEF : 32'h0000_1234);
        end
        hold = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("tie_count", 32'(order.size()), 32'd4);
        for (int j = 0; j < order.size(); j++) begin
            chk("tie_order", 32'(order[j]), 32'(j % 2));
            if (j > 0) chk("tie_spacing", 32'(stamp[j] - stamp[j-1]), 32'd5);
        end
        run(3);

        // Reset in the middle of a write strobe
        issue(0, 1'b1, 16'h0300, 16'h5555);
        run(2);
        #3;
        reset_n = 1'b0;
        model_reset();
        bus.req0 = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'(obs_vec()), 32'h0000_00F8);
        chk("mid_rst_addr", 32'(bus.Mem_ADDR), 32'd0);
        chk("mid_rst_dout", 32'(bus.Mem_DOUT), 32'd0);
        chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        run(2);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_nowrite", 32'(sram[16'h0300]), 32'(exp_mem[16'h0300]));
        issue(0, 1'b0, 16'h0010, 16'h0000);
        run(4);
        chk("post_rst_done0", 32'(bus.done0), 32'd1);
        run(2);

        // Port inputs change during the strobe
        issue(0, 1'b0, 16'h0010, 16'h0000);
        run(2);
        bus.addr0 = 16'h0FFF;
        bus.req0 = 1'b0;
        run(1);
        chk("hold_addr", 32'(bus.Mem_ADDR), 32'h0000_0010);
        run(1);
        chk("mid_change_done0", 32'(bus.done0), 32'd1);
        run(3);
        chk("mid_change_idle", 32'(bus.Mem_CE), 32'd1);

        // Strobe width 1 and 15
        bus1.addr0 = 16'h0005;  bus1.req0 = 1'b1;
        bus15.addr0 = 16'h0007; bus15.req0 = 1'b1;
        d1c = 0; d15c = 0; oe1 = 0; oe15 = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (!bus1.Mem_OE) oe1++;
            if (!bus15.Mem_OE) oe15++;
            if (bus1.done0) begin
                if (d1c == 0) d1c = c;
                bus1.req0 = 1'b0;
                chk("w1_rdata", 32'(bus1.rdata), 32'h0000_A5A5);
            end
            if (bus15.done0) begin
                if (d15c == 0) d15c = c;
                bus15.req0 = 1'b0;
                chk("w15_rdata", 32'(bus15.rdata), 32'h0000_5A5A);
            end
        end
        chk("w1_done_cycle", 32'(d1c), 32'd3);
        chk("w1_strobe_width", 32'(oe1), 32'd1);
        chk("w15_done_cycle", 32'(d15c), 32'd17);
        chk("w15_strobe_width", 32'(oe15), 32'd15);

        // Random two-port traffic
        for (int c = 0; c < 400; c++) begin
            if (!bus.req0 && $urandom_range(0, 2) == 0)
                issue(0, 1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom));
            if (!bus.req1 && $urandom_range(0, 2) == 0)
                issue(1, 1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 15)), 16'($urandom));
            tick();
        end
        guard = 0;
        while ((bus.req0 || bus.req1 || k != 0) && guard < 40) begin
            tick();
            guard++;
        end
        chk("drain_timeout", 32'(bus.req0 | bus.req1), 32'd0);
        for (int a = 16'h0040; a < 16'h0050; a++)
            chk("mem_final", 32'(sram[a]), 32'(exp_mem[a]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Two-port SRAM access sequencer and arbiter for the SLC-3 memory interface. Port 0 serves the CPU datapath (fetch, load and store requests issued by the control unit). Port 1 serves a debug/loader requester. The block arbitrates round-robin between the two ports, then drives the active-low SRAM strobes through a fixed setup/strobe/recover sequence with a programmable strobe width. It replaces direct strobe generation in the control states, so the control unit only issues a request and waits for `done`.

## Interface
- `ADDR_W`, 16: address width, both ports and SRAM.
- `DATA_W`, 16: data width.
- `WAIT_CYCLES`, 2: cycles `Mem_OE`/`Mem_WE` are held low. Legal range is 1–15.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset; state is cleared while `Reset`=0.
- `req0`, `req1` input 1 each: access request, level, per port.
- `we0`, `we1` input 1 each: 1 = write, 0 = read.
- `addr0`, `addr1` input ADDR_W each: word address.
- `wdata0`, `wdata1` input DATA_W each: write data.
- `done0`, `done1` output 1 each: one-cycle completion pulse.
- `rdata` output DATA_W: read data, valid while the matching `doneN`=1; holds until the next read completes.
- `Mem_ADDR` output ADDR_W: SRAM address.
- `Mem_DOUT` output DATA_W: write data to the SRAM pad.
- `Mem_DOE` output 1: pad output enable, 1 = drive bus.
- `Mem_DIN` input DATA_W: read data from the SRAM pad.
- `Mem_CE`, `Mem_UB`, `Mem_LB`, `Mem_OE`, `Mem_WE` output 1 each: SRAM controls, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- **IDLE**
  - All strobes are high (`Mem_CE`, `Mem_UB`, `Mem_LB`, `Mem_OE`, `Mem_WE` = 1).
  - `req0`/`req1` are sampled only on the edge leaving IDLE.
  - If any request is high, the block selects the owner, latches that port's `we`/`addr`/`wdata` into internal registers, and moves to SETUP.
- **Arbitration**
  - A single requester wins outright.
  - On a tie, the port that did not own the previous transaction wins.
  - The last-owner pointer resets to 1, so port 0 wins the first tie.
  - The pointer updates on every grant.
- **SETUP** (1 cycle)
  - `Mem_CE`=`Mem_UB`=`Mem_LB`=0.
  - `Mem_ADDR` = latched address.
  - `Mem_OE`=`Mem_WE`=1.
  - `Mem_DOE` = latched `we`.
- **STROBE** (WAIT_CYCLES cycles)
  - As SETUP, plus `Mem_OE`=0 for a read or `Mem_WE`=0 for a write.
  - A 4-bit down-counter loads WAIT_CYCLES-1 on entry and leaves STROBE when it reaches 0.
  - For a read, `rdata` captures `Mem_DIN` on the edge leaving STROBE.
- **RECOVER** (1 cycle)
  - `Mem_OE`=`Mem_WE`=1.
  - `Mem_CE`/`Mem_UB`/`Mem_LB` stay 0, and address and `Mem_DOE` stay held.
  - `doneN`=1 for the owner only. Next state is IDLE.
- **Request changes during a transaction:** once latched, a transaction always completes. Port inputs and `req` changes are ignored until the next IDLE.
- **Requester protocol:** a requester that clears `req` on the edge where it samples `doneN`=1 issues exactly one transaction. Holding `req` high issues back-to-back transactions, subject to arbitration.
- **Bus safety:** `Mem_DOE` is never 1 in any cycle where `Mem_OE`=0.
- **Reset** (at any time, including mid-STROBE):
  - FSM returns to IDLE and the counter clears.
  - All SRAM strobes = 1, `Mem_DOE`=0, `Mem_ADDR`=0, `Mem_DOUT`=0.
  - `rdata`=0, `done0`=`done1`=0, last-owner = 1.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `reqN` to any output.
- **Latency:** `req` high in IDLE cycle 0 gives SETUP in cycle 1, STROBE in cycles 2..1+WAIT_CYCLES, and `doneN` in cycle 2+WAIT_CYCLES.
  - WAIT_CYCLES=2 gives `done` in cycle 4, i.e. 5 cycles per transaction including IDLE.
- **Throughput:** one transaction per WAIT_CYCLES+3 cycles.
- **Release from reset:** on the first rising edge after `Reset` goes to 1, the FSM is in IDLE, and `req` may be accepted on that edge.

## Test plan
- **Read, port 0:** preload SRAM model [0x0010]=0xBEEF; `req0`=1, `we0`=0, `addr0`=0x0010, WAIT_CYCLES=2.
  - Expect `Mem_CE` low cycles 1–4, `Mem_OE` low cycles 2–3, `done0`=1 in cycle 4 only, `rdata`=0xBEEF, `Mem_DOE`=0 throughout.
- **Write, port 1:** `req1`=1, `we1`=1, `addr1`=0x0200, `wdata1`=0x1234.
  - Expect `Mem_WE` low cycles 2–3, `Mem_DOE`=1 cycles 1–4, `Mem_DOUT`=0x1234.
  - Model [0x0200]=0x1234, `done1` pulse in cycle 4, `done0` stays 0.
- **Simultaneous requests:** `req0` and `req1` held high from reset.
  - Grant order is 0,1,0,1.
  - Each `done` is 5 cycles apart, and `rdata` matches each port's address.
- **Reset mid-STROBE:** assert `Reset`=0 during cycle 2 of a write.
  - Expect all strobes =1 and `Mem_DOE`=0 immediately (asynchronously).
  - No `done` pulse. After release, a fresh `req0` completes normally.
- **Request changes mid-transaction:** change `addr0` to 0x0FFF and drop `req0` during STROBE.
  - `Mem_ADDR` stays at the original 0x0010, the transaction completes with a `done0` pulse, and FSM then idles.
- **WAIT_CYCLES=1 and 15:** strobe width is 1 and 15 cycles respectively, with `done` in cycle 3 and 17.
